dm_cache_ctrl: RTL

//   Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the

---
 rtl/dm_cache_ctrl_pkg.sv | 46 ++++
 rtl/dm_cache_ctrl_line_array.sv | 59 +++++
 rtl/dm_cache_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared geometry, address layout, FSM encoding and small helpers for the
// direct-mapped write-back data cache.
package dm_cache_ctrl_pkg;

  localparam int unsigned C_BLOCK_SIZE = 2;
  localparam int unsigned C_LINE_SIZE  = 32;
  localparam int unsigned ADDRESS_SIZE = 32;
  localparam int unsigned C_INDEX_SIZE = 3;

  localparam int unsigned WORDS   = 1 << C_BLOCK_SIZE;
  localparam int unsigned LINES   = 1 << C_INDEX_SIZE;
  localparam int unsigned BLK_W   = WORDS * C_LINE_SIZE;
  localparam int unsigned TAG_W   = ADDRESS_SIZE - C_INDEX_SIZE - C_BLOCK_SIZE - 2;
  // Memory address is word-granular; the word-select bits are always zero.
  localparam int unsigned MADDR_W = ADDRESS_SIZE - 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_UPDATE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [C_INDEX_SIZE-1:0] index;
    logic [C_BLOCK_SIZE-1:0] word;
    logic [1:0]              byte_off;
  } addr_t;

  function automatic logic [MADDR_W-1:0] blk_addr(input logic [TAG_W-1:0]        tag,
                                                  input logic [C_INDEX_SIZE-1:0] idx);
    return {tag, idx, {C_BLOCK_SIZE{1'b0}}};
  endfunction

  function automatic logic [C_LINE_SIZE-1:0] get_word(input logic [BLK_W-1:0]        blk,
                                                      input logic [C_BLOCK_SIZE-1:0] sel);
    logic [C_LINE_SIZE-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (sel == C_BLOCK_SIZE'(i)) w = blk[i*C_LINE_SIZE +: C_LINE_SIZE];
    end
    return w;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_line_array.sv
// Valid/dirty/tag/data storage for the cache: one word-write port for CPU
// store hits and one block-fill port for refills, both at the read index.
module dm_cache_ctrl_line_array
  import dm_cache_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [C_INDEX_SIZE-1:0] idx_i,
  output logic                    valid_o,
  output logic                    dirty_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [BLK_W-1:0]        data_o,
  input  logic                    word_we_i,
  input  logic [C_BLOCK_SIZE-1:0] word_sel_i,
  input  logic [C_LINE_SIZE-1:0]  word_data_i,
  input  logic                    fill_we_i,
  input  logic [TAG_W-1:0]        fill_tag_i,
  input  logic [BLK_W-1:0]        fill_data_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BLK_W-1:0] data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  // Status bits: cleared by reset, so a reset drops any dirty data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data payload carry no reset; they are qualified by valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_we_i) begin
        tag_q[idx_i]  <= fill_tag_i;
        data_q[idx_i] <= fill_data_i;
      end else if (word_we_i) begin
        for (int i = 0; i < int'(WORDS); i++) begin
          if (word_sel_i == C_BLOCK_SIZE'(i))
            data_q[idx_i][i*C_LINE_SIZE +: C_LINE_SIZE] <= word_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller: hit compare,
// CPU word muxing and the writeback/allocate/update miss FSM.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
(
  input  logic                     c_clk_i,
  input  logic                     c_reset_i,
  input  logic                     c_read_i,
  input  logic                     c_write_i,
  input  logic [ADDRESS_SIZE-1:0]  c_addr_i,
  input  logic [C_LINE_SIZE-1:0]   c_wr_data_i,
  output logic [C_LINE_SIZE-1:0]   c_read_data_o,
  output logic                     c_busywait_o,
  output logic                     m_read_o,
  output logic                     m_wr_o,
  output logic [MADDR_W-1:0]       m_addr_o,
  output logic [BLK_W-1:0]         m_wr_data_o,
  input  logic [BLK_W-1:0]         m_read_data_i,
  input  logic                     m_busywait_i,
  input  logic                     m_read_done_i,
  input  logic                     m_write_done_i
);

  state_e               state_q, state_d;
  logic                 m_read_q, m_read_d;
  logic                 m_wr_q, m_wr_d;
  logic [MADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [BLK_W-1:0]     m_wr_data_q, m_wr_data_d;
  logic [BLK_W-1:0]     fill_data_q, fill_data_d;

  addr_t                req;
  logic                 ln_valid, ln_dirty;
  logic [TAG_W-1:0]     ln_tag;
  logic [BLK_W-1:0]     ln_data;
  logic                 hit_c, req_c, busy_c, word_we_c, fill_we_c;
  logic                 unused_c;

  assign req   = addr_t'(c_addr_i);
  assign hit_c = ln_valid && (ln_tag == req.tag);
  assign req_c = c_read_i || c_write_i;

  // Memory handshake is driven purely by the done pulses.
  assign unused_c = ^{m_busywait_i, req.byte_off};

  dm_cache_ctrl_line_array u_lines (
    .clk_i       (c_clk_i),
    .rst_i       (c_reset_i),
    .idx_i       (req.index),
    .valid_o     (ln_valid),
    .dirty_o     (ln_dirty),
    .tag_o       (ln_tag),
    .data_o      (ln_data),
    .word_we_i   (word_we_c),
    .word_sel_i  (req.word),
    .word_data_i (c_wr_data_i),
    .fill_we_i   (fill_we_c),
    .fill_tag_i  (req.tag),
    .fill_data_i (fill_data_q)
  );

  always_ff @(posedge c_clk_i) begin
    if (c_reset_i) begin
      state_q     <= ST_IDLE;
      m_read_q    <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wr_data_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      m_read_q    <= m_read_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Memory-side outputs are registered from the next state so they are
  // valid for exactly the cycles spent in WRITEBACK / ALLOCATE.
  always_comb begin
    state_d     = state_q;
    m_read_d    = m_read_q;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    fill_data_d = fill_data_q;
    busy_c      = 1'b0;
    word_we_c   = 1'b0;
    fill_we_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            word_we_c = c_write_i;
          end else begin
            busy_c = 1'b1;
            if (ln_valid && ln_dirty) begin
              state_d     = ST_WRITEBACK;
              m_wr_d      = 1'b1;
              m_addr_d    = blk_addr(ln_tag, req.index);
              m_wr_data_d = ln_data;
            end else begin
              state_d  = ST_ALLOCATE;
              m_read_d = 1'b1;
              m_addr_d = blk_addr(req.tag, req.index);
            end
          end
        end
      end
      ST_WRITEBACK: begin
        busy_c = 1'b1;
        if (m_write_done_i) begin
          state_d  = ST_ALLOCATE;
          m_wr_d   = 1'b0;
          m_read_d = 1'b1;
          m_addr_d = blk_addr(req.tag, req.index);
        end
      end
      ST_ALLOCATE: begin
        busy_c = 1'b1;
        if (m_read_done_i) begin
          state_d     = ST_UPDATE;
          m_read_d    = 1'b0;
          fill_data_d = m_read_data_i;
        end
      end
      ST_UPDATE: begin
        busy_c    = 1'b1;
        fill_we_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign c_busywait_o  = busy_c;
  assign c_read_data_o = get_word(ln_data, req.word);
  assign m_read_o      = m_read_q;
  assign m_wr_o        = m_wr_q;
  assign m_addr_o      = m_addr_q;
  assign m_wr_data_o   = m_wr_data_q;

endmodule
